kse: RTL and testbench

KSE -- requirements
Module: kse

---
 rtl/kse.sv | 139 +++++++++++++
 tb/tb_kse.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kse.sv
// 4x4 keypad scanner: rotates an active-low column drive, debounces a single-row
// press, reports it as two BCD digits and waits for a debounced release.
module kse #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    input  logic       read,
    output logic [7:0] BCD,
    output logic       valid,
    output logic [3:0] col,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DC_LAST = CW'(DEBOUNCE_CYCLES);

    // Handshake: valid rises on the acceptance edge and falls on the first later
    // edge with read high; an acceptance on the same edge as read keeps valid high.

    state_t        state_q, state_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    row_cap_q, row_cap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    bcd_q, bcd_d;
    logic          valid_q, valid_d;

    logic          accept;
    logic          row_single;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    key;
    logic [7:0]    key_bcd;

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        case (v)
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: low_idx = 2'd0;
        endcase
    endfunction

    assign row_single = (row == 4'b1110) || (row == 4'b1101) ||
                        (row == 4'b1011) || (row == 4'b0111);
    assign cnt_inc    = cnt_q + CW'(1);
    // The accepted row always equals the live row, so the code is taken from it.
    assign key        = {low_idx(row), low_idx(col_q)};
    assign key_bcd    = (key >= 4'd10) ? {4'd1, key - 4'd10} : {4'd0, key};

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_cap_d = row_cap_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        case (state_q)
            SCAN: begin
                if (row_single) begin
                    row_cap_d = row;
                    cnt_d     = CW'(1);
                    if (DEBOUNCE_CYCLES <= 1) begin
                        accept  = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT_RELEASE;
                    end else begin
                        state_d = DEBOUNCE;
                    end
                end else begin
                    col_d = {col_q[2:0], col_q[3]};
                end
            end
            DEBOUNCE: begin
                if (row == row_cap_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= DC_LAST) begin
                        accept  = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT_RELEASE;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            WAIT_RELEASE: begin
                if (row == 4'b1111) begin
                    if (cnt_inc >= DC_LAST) begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = SCAN;
            end
        endcase
    end

    always_comb begin
        bcd_d   = accept ? key_bcd : bcd_q;
        valid_d = accept ? 1'b1 : (read ? 1'b0 : valid_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= SCAN;
            col_q     <= 4'b1110;
            row_cap_q <= 4'b1111;
            cnt_q     <= '0;
            bcd_q     <= 8'h00;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_cap_q <= row_cap_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
        end
    end

    assign BCD     = bcd_q;
    assign valid   = valid_q;
    assign col     = col_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_kse.sv
// Directed bench for the keypad scanner: a vector table for scan/accept/release,
// then hand sequences for overwrite, bounce, release glitch, reset and read races.
module tb_kse;

    logic       clock;
    logic       reset;
    logic [3:0] row;
    logic       read;
    logic [7:0] BCD;
    logic       valid;
    logic [3:0] col;
    logic [1:0] state_o;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [1:0] S_SCAN = 2'd0;
    localparam logic [1:0] S_DEB  = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    kse #(.DEBOUNCE_CYCLES(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .row     (row),
        .read    (read),
        .BCD     (BCD),
        .valid   (valid),
        .col     (col),
        .state_o (state_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded, required end of test");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0] row;
        logic       rd;
        logic [3:0] exp_col;
        logic [7:0] exp_bcd;
        logic       exp_valid;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] rot(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

    // Idles with no key until the column drive reaches target (bounded).
    task automatic wait_col(input logic [3:0] target);
        int n;
        n   = 0;
        row = 4'b1111;
        while (col !== target && n < 8) begin
            tick();
            n++;
        end
        check("wait_col", {4'h0, col}, {4'h0, target});
    endtask

    initial begin
        int nacc;
        logic [3:0] c0;

        // Reset idle scan, read pulse, then key r0c0 accept and release.
        for (int i = 0; i < 8; i++) begin
            vecs[i].row = 4'b1111; vecs[i].rd = 1'b0; vecs[i].exp_bcd = 8'h00;
            vecs[i].exp_valid = 1'b0; vecs[i].exp_state = S_SCAN;
        end
        vecs[0].exp_col = 4'b1101; vecs[1].exp_col = 4'b1011;
        vecs[2].exp_col = 4'b0111; vecs[3].exp_col = 4'b1110;
        vecs[4].exp_col = 4'b1101; vecs[5].exp_col = 4'b1011;
        vecs[6].exp_col = 4'b0111; vecs[7].exp_col = 4'b1110;
        vecs[8]  = '{4'b1111, 1'b1, 4'b1101, 8'h00, 1'b0, S_SCAN};
        vecs[9]  = '{4'b1111, 1'b0, 4'b1011, 8'h00, 1'b0, S_SCAN};
        vecs[10] = '{4'b1111, 1'b0, 4'b0111, 8'h00, 1'b0, S_SCAN};
        vecs[11] = '{4'b1111, 1'b0, 4'b1110, 8'h00, 1'b0, S_SCAN};
        vecs[12] = '{4'b1110, 1'b0, 4'b1110, 8'h00, 1'b0, S_DEB};
        vecs[13] = '{4'b1110, 1'b0, 4'b1110, 8'h00, 1'b0, S_DEB};
        vecs[14] = '{4'b1110, 1'b0, 4'b1110, 8'h00, 1'b0, S_DEB};
        vecs[15] = '{4'b1110, 1'b0, 4'b1110, 8'h00, 1'b1, S_WR};
        vecs[16] = '{4'b1111, 1'b0, 4'b1110, 8'h00, 1'b1, S_WR};
        vecs[17] = '{4'b1111, 1'b0, 4'b1110, 8'h00, 1'b1, S_WR};
        vecs[18] = '{4'b1111, 1'b0, 4'b1110, 8'h00, 1'b1, S_WR};
        vecs[19] = '{4'b1111, 1'b0, 4'b1110, 8'h00, 1'b1, S_SCAN};
        vecs[20] = '{4'b1111, 1'b1, 4'b1101, 8'h00, 1'b0, S_SCAN};
        vecs[21] = '{4'b1111, 1'b0, 4'b1011, 8'h00, 1'b0, S_SCAN};

        reset = 1'b1;
        row   = 4'b1111;
        read  = 1'b0;
        #12;
        check("rst_col", {4'h0, col}, 8'h0E);
        check("rst_valid", {7'h0, valid}, 8'h00);
        check("rst_bcd", BCD, 8'h00);
        check("rst_state", {6'h0, state_o}, {6'h0, S_SCAN});
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            row  = vecs[i].row;
            read = vecs[i].rd;
            tick();
            check($sformatf("vec%0d_col", i), {4'h0, col}, {4'h0, vecs[i].exp_col});
            check($sformatf("vec%0d_bcd", i), BCD, vecs[i].exp_bcd);
            check($sformatf("vec%0d_valid", i), {7'h0, valid}, {7'h0, vecs[i].exp_valid});
            check($sformatf("vec%0d_state", i), {6'h0, state_o}, {6'h0, vecs[i].exp_state});
        end
        read = 1'b0;

        // Key 9 (r2c1), release, then key 15 (r3c3) while valid is still set.
        wait_col(4'b1101);
        row = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("k9_deb_state", {6'h0, state_o}, {6'h0, S_DEB});
        end
        tick();
        check("k9_bcd", BCD, 8'h09);
        check("k9_valid", {7'h0, valid}, 8'h01);
        check("k9_state", {6'h0, state_o}, {6'h0, S_WR});
        row = 4'b1111;
        for (int i = 0; i < 4; i++) tick();
        check("k9_rel_state", {6'h0, state_o}, {6'h0, S_SCAN});
        check("k9_rel_col", {4'h0, col}, 8'h0D);
        wait_col(4'b0111);
        row = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("k15_pre_valid", {7'h0, valid}, 8'h01);
            check("k15_pre_bcd", BCD, 8'h09);
        end
        tick();
        check("k15_bcd", BCD, 8'h15);
        check("k15_valid", {7'h0, valid}, 8'h01);
        row = 4'b1111;
        for (int i = 0; i < 4; i++) tick();
        check("k15_rel_state", {6'h0, state_o}, {6'h0, S_SCAN});

        // Bounce on row 1: never held long enough to be accepted.
        read = 1'b1;
        tick();
        read = 1'b0;
        check("bnc_clr_valid", {7'h0, valid}, 8'h00);
        for (int rep = 0; rep < 4; rep++) begin
            row = 4'b1101;
            for (int k = 0; k <= rep % 2; k++) begin
                tick();
                check("bnc_valid", {7'h0, valid}, 8'h00);
            end
            row = 4'b1111;
            tick();
            check("bnc_bcd", BCD, 8'h15);
            check("bnc_state", {6'h0, state_o}, {6'h0, S_SCAN});
        end
        c0 = col;
        tick();
        check("bnc_rot1", {4'h0, col}, {4'h0, rot(c0)});
        tick();
        check("bnc_rot2", {4'h0, col}, {4'h0, rot(rot(c0))});

        // Long hold with a 2-clock release glitch; read held high so valid
        // is visible only on an acceptance edge.
        wait_col(4'b1110);
        read = 1'b1;
        nacc = 0;
        for (int i = 0; i < 20; i++) begin
            row = (i == 9 || i == 10) ? 4'b1111 : 4'b1110;
            tick();
            if (valid) nacc++;
        end
        check("glitch_accepts", nacc[7:0], 8'd1);
        check("glitch_bcd", BCD, 8'h00);
        check("glitch_state", {6'h0, state_o}, {6'h0, S_WR});
        read = 1'b0;
        row  = 4'b1111;
        for (int i = 0; i < 4; i++) tick();
        check("glitch_rel_state", {6'h0, state_o}, {6'h0, S_SCAN});

        // Reset aborting DEBOUNCE with a key pending.
        wait_col(4'b1101);
        row = 4'b1011;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_valid", {7'h0, valid}, 8'h01);
        row = 4'b1111;
        for (int i = 0; i < 4; i++) tick();
        wait_col(4'b1011);
        row = 4'b1110;
        tick();
        tick();
        check("mid_deb_state", {6'h0, state_o}, {6'h0, S_DEB});
        #2;
        reset = 1'b1;
        #1;
        check("arst_col", {4'h0, col}, 8'h0E);
        check("arst_valid", {7'h0, valid}, 8'h00);
        check("arst_bcd", BCD, 8'h00);
        check("arst_state", {6'h0, state_o}, {6'h0, S_SCAN});
        @(negedge clock);
        reset = 1'b0;
        row   = 4'b1111;
        tick();
        check("post_rst_col", {4'h0, col}, 8'h0D);
        check("post_rst_state", {6'h0, state_o}, {6'h0, S_SCAN});

        // Read coinciding with the acceptance edge.
        wait_col(4'b0111);
        row = 4'b0111;
        for (int i = 0; i < 3; i++) tick();
        read = 1'b1;
        tick();
        check("race_valid", {7'h0, valid}, 8'h01);
        check("race_bcd", BCD, 8'h15);
        tick();
        read = 1'b0;
        check("race_clr_valid", {7'h0, valid}, 8'h00);
        check("race_hold_col", {4'h0, col}, 8'h07);
        row = 4'b1111;
        for (int i = 0; i < 4; i++) tick();
        check("race_rel_state", {6'h0, state_o}, {6'h0, S_SCAN});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
